vector_alu: RTL and testbench

VECTOR_ALU -- requirements
Module: vector_alu

---
 rtl/vector_alu.sv | 149 ++++++++++++++
 tb/tb_vector_alu.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vector_alu.sv
// Lane-parallel vector ALU: 16 x 32-bit lanes, LANES_PER_CYCLE lanes per EXEC cycle.
// Results are written back through a registered port during the cycle after the WRITE state.
module vector_alu #(
  parameter int LANES_PER_CYCLE = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [1:0]   src_a,
  input  logic [1:0]   src_b,
  input  logic [1:0]   dst_lo,
  input  logic [1:0]   dst_hi,
  input  logic [511:0] register0,
  input  logic [511:0] register1,
  input  logic [511:0] register2,
  input  logic [511:0] register3,
  output logic         busy,
  output logic         done,
  output logic         we1,
  output logic         we2,
  output logic [1:0]   out_reg1,
  output logic [1:0]   out_reg2,
  output logic [511:0] out_data1,
  output logic [511:0] out_data2,
  output logic [1:0]   dbg_state
);

  localparam int GROUPS = 16 / LANES_PER_CYCLE;
  localparam int CW = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam logic [CW-1:0] LAST_GROUP = CW'(GROUPS - 1);
  localparam logic [1:0] OP_MUL = 2'b10;

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, WRITE = 2'd2} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [1:0]    op_q, dlo_q, dhi_q;
  logic [31:0]   a_q  [16];
  logic [31:0]   b_q  [16];
  logic [31:0]   lo_r [16];
  logic [31:0]   hi_r [16];
  logic [511:0]  rd_a, rd_b;
  logic [31:0]   grp_lo [LANES_PER_CYCLE];
  logic [31:0]   grp_hi [LANES_PER_CYCLE];

  assign dbg_state = state;

  // Returns {hi, lo}; hi is only meaningful for the signed multiply.
  function automatic logic [63:0] lane_op(input logic [1:0] f, input logic [31:0] a,
                                          input logic [31:0] b);
    logic signed [63:0] p;
    p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    case (f)
      2'b00:   lane_op = {32'h0, a + b};
      2'b01:   lane_op = {32'h0, a - b};
      2'b10:   lane_op = p;
      default: lane_op = {32'h0, a ^ b};
    endcase
  endfunction

  function automatic logic [3:0] lane_of(input logic [CW-1:0] c, input int j);
    lane_of = 4'(int'(c) * LANES_PER_CYCLE + j);
  endfunction

  always_comb begin
    rd_a = register0;
    rd_b = register0;
    case (src_a)
      2'd1:    rd_a = register1;
      2'd2:    rd_a = register2;
      2'd3:    rd_a = register3;
      default: rd_a = register0;
    endcase
    case (src_b)
      2'd1:    rd_b = register1;
      2'd2:    rd_b = register2;
      2'd3:    rd_b = register3;
      default: rd_b = register0;
    endcase
  end

  always_comb begin
    for (int j = 0; j < LANES_PER_CYCLE; j++) begin
      {grp_hi[j], grp_lo[j]} = lane_op(op_q, a_q[lane_of(cnt, j)], b_q[lane_of(cnt, j)]);
    end
  end

  // busy stays high through the registered write-back cycle that follows WRITE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      we1       <= 1'b0;
      we2       <= 1'b0;
      out_reg1  <= '0;
      out_reg2  <= '0;
      out_data1 <= '0;
      out_data2 <= '0;
    end else begin
      done <= 1'b0;
      we1  <= 1'b0;
      we2  <= 1'b0;
      case (state)
        IDLE: begin
          busy <= start;
          if (start) begin
            op_q  <= op;
            dlo_q <= dst_lo;
            dhi_q <= dst_hi;
            for (int i = 0; i < 16; i++) begin
              a_q[i] <= rd_a[32*i +: 32];
              b_q[i] <= rd_b[32*i +: 32];
            end
            cnt   <= '0;
            state <= EXEC;
          end
        end
        EXEC: begin
          for (int j = 0; j < LANES_PER_CYCLE; j++) begin
            lo_r[lane_of(cnt, j)] <= grp_lo[j];
            hi_r[lane_of(cnt, j)] <= grp_hi[j];
          end
          cnt <= cnt + 1'b1;
          if (cnt == LAST_GROUP) state <= WRITE;
        end
        WRITE: begin
          we1      <= 1'b1;
          done     <= 1'b1;
          we2      <= (op_q == OP_MUL);
          out_reg1 <= dlo_q;
          out_reg2 <= dhi_q;
          for (int i = 0; i < 16; i++) begin
            out_data1[32*i +: 32] <= lo_r[i];
            out_data2[32*i +: 32] <= hi_r[i];
          end
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vector_alu.sv
// Bench for vector_alu: directed scenarios plus randomized ops against a lane-level model,
// with three instances covering LANES_PER_CYCLE = 4, 1 and 16.
module tb_vector_alu;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   op = '0, src_a = '0, src_b = '0, dst_lo = '0, dst_hi = '0;
  logic [511:0] rf [4];

  logic         busy, done, we1, we2;
  logic [1:0]   out_reg1, out_reg2, dbg_state;
  logic [511:0] out_data1, out_data2;
  logic         busy_a, done_a, we1_a, we2_a;
  logic [1:0]   out_reg1_a, out_reg2_a, dbg_state_a;
  logic [511:0] out_data1_a, out_data2_a;
  logic         busy_b, done_b, we1_b, we2_b;
  logic [1:0]   out_reg1_b, out_reg2_b, dbg_state_b;
  logic [511:0] out_data1_b, out_data2_b;

  int n_cmp = 0;
  int n_err = 0;
  logic [511:0] exp_q[$];

  always #5 clk = ~clk;

  vector_alu #(.LANES_PER_CYCLE(4)) u_dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
    .dst_lo(dst_lo), .dst_hi(dst_hi), .register0(rf[0]), .register1(rf[1]),
    .register2(rf[2]), .register3(rf[3]), .busy(busy), .done(done), .we1(we1), .we2(we2),
    .out_reg1(out_reg1), .out_reg2(out_reg2), .out_data1(out_data1), .out_data2(out_data2),
    .dbg_state(dbg_state));

  vector_alu #(.LANES_PER_CYCLE(1)) u_l1 (
    .clk(clk), .rst(rst), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
    .dst_lo(dst_lo), .dst_hi(dst_hi), .register0(rf[0]), .register1(rf[1]),
    .register2(rf[2]), .register3(rf[3]), .busy(busy_a), .done(done_a), .we1(we1_a),
    .we2(we2_a), .out_reg1(out_reg1_a), .out_reg2(out_reg2_a), .out_data1(out_data1_a),
    .out_data2(out_data2_a), .dbg_state(dbg_state_a));

  vector_alu #(.LANES_PER_CYCLE(16)) u_l16 (
    .clk(clk), .rst(rst), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
    .dst_lo(dst_lo), .dst_hi(dst_hi), .register0(rf[0]), .register1(rf[1]),
    .register2(rf[2]), .register3(rf[3]), .busy(busy_b), .done(done_b), .we1(we1_b),
    .we2(we2_b), .out_reg1(out_reg1_b), .out_reg2(out_reg2_b), .out_data1(out_data1_b),
    .out_data2(out_data2_b), .dbg_state(dbg_state_b));

  // ---------------- reference model ----------------
  // Returns {hi, lo} for a whole vector, computed lane by lane with plain arithmetic.
  function automatic logic [1023:0] ref_result(input logic [1:0] f, input logic [511:0] a,
                                               input logic [511:0] b);
    logic [511:0] lo, hi;
    logic [31:0] x, y;
    longint p;
    lo = '0;
    hi = '0;
    for (int i = 0; i < 16; i++) begin
      x = a[32*i +: 32];
      y = b[32*i +: 32];
      p = longint'($signed(x)) * longint'($signed(y));
      case (f)
        2'b00: lo[32*i +: 32] = x + y;
        2'b01: lo[32*i +: 32] = x - y;
        2'b10: begin
          lo[32*i +: 32] = p[31:0];
          hi[32*i +: 32] = p[63:32];
        end
        default: lo[32*i +: 32] = x ^ y;
      endcase
    end
    return {hi, lo};
  endfunction

  function automatic logic [31:0] rand_lane();
    case ($urandom_range(0, 5))
      0:       return 32'hFFFF_FFFF;
      1:       return 32'h8000_0000;
      2:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [511:0] rand_vec();
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[32*i +: 32] = rand_lane();
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] f, input logic [1:0] sa, input logic [1:0] sb,
                       input logic [1:0] dl, input logic [1:0] dh);
    op = f; src_a = sa; src_b = sb; dst_lo = dl; dst_hi = dh;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Edges after the accepting edge until we1 is seen on the main instance (bounded).
  task automatic wait_we1(output int lat);
    lat = 0;
    while (we1 !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    n_cmp++;
    if ({busy, done, we1, we2, out_reg1, out_reg2, dbg_state} !== 11'b0) begin
      n_err++;
      $display("FAIL reset_ctrl: got %b expected 0",
               {busy, done, we1, we2, out_reg1, out_reg2, dbg_state});
    end
    n_cmp++;
    if (out_data1 !== 512'b0 || out_data2 !== 512'b0) begin
      n_err++;
      $display("FAIL reset_data: got %h / %h expected 0", out_data1, out_data2);
    end
    n_cmp++;
    if ({busy_a, we1_a, we2_a, done_a, busy_b, we1_b, we2_b, done_b} !== 8'b0) begin
      n_err++;
      $display("FAIL reset_other_lanes: got %b expected 0",
               {busy_a, we1_a, we2_a, done_a, busy_b, we1_b, we2_b, done_b});
    end
  endtask

  task automatic test_add();
    int lat;
    rf[0] = {16{32'hFFFF_FFFF}};
    rf[1] = {16{32'h0000_0002}};
    issue(2'b00, 2'd0, 2'd1, 2'd2, 2'd3);
    wait_we1(lat);
    n_cmp++;
    if (lat !== 5) begin n_err++; $display("FAIL add_latency: got %0d expected 5", lat); end
    n_cmp++;
    if ({we1, we2, done, out_reg1} !== 5'b1_0_1_10) begin
      n_err++;
      $display("FAIL add_ctrl: got we1=%b we2=%b done=%b reg=%0d expected 1 0 1 2",
               we1, we2, done, out_reg1);
    end
    n_cmp++;
    if (out_data1 !== {16{32'h0000_0001}}) begin
      n_err++;
      $display("FAIL add_data: got %h expected all lanes 00000001", out_data1);
    end
    tick();
    n_cmp++;
    if ({we1, we2, done, busy} !== 4'b0) begin
      n_err++;
      $display("FAIL add_pulse_end: got %b expected 0000", {we1, we2, done, busy});
    end
  endtask

  task automatic test_mul();
    int lat;
    rf[2] = {16{32'hFFFF_FFFD}};
    rf[3] = {16{32'h0000_0005}};
    issue(2'b10, 2'd2, 2'd3, 2'd2, 2'd3);
    wait_we1(lat);
    n_cmp++;
    if (lat !== 5 || {we1, we2, done} !== 3'b111 || out_reg1 !== 2'd2 || out_reg2 !== 2'd3) begin
      n_err++;
      $display("FAIL mul_ctrl: got lat=%0d we1=%b we2=%b done=%b r1=%0d r2=%0d expected 5 1 1 1 2 3",
               lat, we1, we2, done, out_reg1, out_reg2);
    end
    n_cmp++;
    if (out_data1 !== {16{32'hFFFF_FFF1}}) begin
      n_err++;
      $display("FAIL mul_lo: got %h expected all lanes fffffff1", out_data1);
    end
    n_cmp++;
    if (out_data2 !== {16{32'hFFFF_FFFF}}) begin
      n_err++;
      $display("FAIL mul_hi: got %h expected all lanes ffffffff", out_data2);
    end
    tick();
  endtask

  task automatic test_lanes();
    int lat4, lat1, lat16;
    logic [511:0] d4, d1, d16, exp_v;
    repeat (20) tick();
    for (int i = 0; i < 16; i++) begin
      rf[0][32*i +: 32] = 32'(i + 100);
      rf[1][32*i +: 32] = 32'(2 * i);
      exp_v[32*i +: 32] = 32'(100 - i);
    end
    lat4 = -1; lat1 = -1; lat16 = -1;
    d4 = '0; d1 = '0; d16 = '0;
    issue(2'b01, 2'd0, 2'd1, 2'd0, 2'd0);
    for (int t = 1; t <= 22; t++) begin
      tick();
      if (we1 === 1'b1 && lat4 < 0) begin lat4 = t; d4 = out_data1; end
      if (we1_a === 1'b1 && lat1 < 0) begin lat1 = t; d1 = out_data1_a; end
      if (we1_b === 1'b1 && lat16 < 0) begin lat16 = t; d16 = out_data1_b; end
    end
    n_cmp++;
    if (lat4 != 5 || lat1 != 17 || lat16 != 2) begin
      n_err++;
      $display("FAIL lanes_latency: got L4=%0d L1=%0d L16=%0d expected 5 17 2", lat4, lat1, lat16);
    end
    n_cmp++;
    if (d4 !== exp_v) begin n_err++; $display("FAIL sub_l4: got %h expected %h", d4, exp_v); end
    n_cmp++;
    if (d1 !== exp_v) begin n_err++; $display("FAIL sub_l1: got %h expected %h", d1, exp_v); end
    n_cmp++;
    if (d16 !== exp_v) begin n_err++; $display("FAIL sub_l16: got %h expected %h", d16, exp_v); end
  endtask

  task automatic test_start_held();
    int pulses[$];
    int busy_bad;
    busy_bad = 0;
    repeat (20) tick();
    op = 2'b11; src_a = 2'd0; src_b = 2'd1; dst_lo = 2'd3; dst_hi = 2'd3;
    start = 1'b1;
    for (int t = 0; t < 20; t++) begin
      tick();
      if (t == 9) start = 1'b0;
      if (we1 === 1'b1) pulses.push_back(t);
      if (t <= 11 && busy !== 1'b1) busy_bad++;
      if (t >= 12 && busy !== 1'b0) busy_bad++;
    end
    n_cmp++;
    if (pulses.size() != 2) begin
      n_err++;
      $display("FAIL held_pulse_count: got %0d expected 2", pulses.size());
    end else begin
      n_cmp++;
      if (pulses[0] != 5 || pulses[1] != 11) begin
        n_err++;
        $display("FAIL held_pulse_time: got %0d,%0d expected 5,11", pulses[0], pulses[1]);
      end
    end
    n_cmp++;
    if (busy_bad != 0) begin
      n_err++;
      $display("FAIL held_busy: got %0d bad cycles expected 0", busy_bad);
    end
  endtask

  task automatic test_reset_mid();
    int seen, lat;
    logic [1023:0] r;
    seen = 0;
    repeat (20) tick();
    rf[0] = rand_vec();
    rf[1] = rand_vec();
    issue(2'b00, 2'd0, 2'd1, 2'd2, 2'd2);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || dbg_state !== 2'd0) begin
      n_err++;
      $display("FAIL rst_mid_idle: got busy=%b state=%0d expected 0 0", busy, dbg_state);
    end
    for (int t = 0; t < 8; t++) begin
      if (we1 === 1'b1 || we2 === 1'b1 || done === 1'b1) seen++;
      tick();
    end
    n_cmp++;
    if (seen != 0) begin n_err++; $display("FAIL rst_mid_write: got %0d pulses expected 0", seen); end
    r = ref_result(2'b00, rf[0], rf[1]);
    issue(2'b00, 2'd0, 2'd1, 2'd2, 2'd2);
    wait_we1(lat);
    n_cmp++;
    if (lat !== 5 || out_data1 !== r[511:0]) begin
      n_err++;
      $display("FAIL rst_mid_fresh: got lat=%0d %h expected 5 %h", lat, out_data1, r[511:0]);
    end
    tick();
  endtask

  task automatic test_mul_same_dst();
    int lat;
    logic [1023:0] r;
    rf[1] = rand_vec();
    rf[2] = rand_vec();
    r = ref_result(2'b10, rf[1], rf[2]);
    issue(2'b10, 2'd1, 2'd2, 2'd1, 2'd1);
    wait_we1(lat);
    n_cmp++;
    if ({we1, we2, done, out_reg1, out_reg2} !== 7'b111_01_01) begin
      n_err++;
      $display("FAIL same_dst_ctrl: got %b expected 1110101", {we1, we2, done, out_reg1, out_reg2});
    end
    n_cmp++;
    if (out_data1 !== r[511:0] || out_data2 !== r[1023:512]) begin
      n_err++;
      $display("FAIL same_dst_data: got hi %h expected %h", out_data2, r[1023:512]);
    end
    tick();
    n_cmp++;
    if ({we1, we2, done} !== 3'b0) begin
      n_err++;
      $display("FAIL same_dst_pulse: got %b expected 000", {we1, we2, done});
    end
  endtask

  // Operands are scrambled while the op executes; results must reflect the values at start.
  task automatic test_random();
    int lat;
    logic [1:0] f, sa, sb, dl, dh;
    logic [1023:0] r;
    logic [511:0] e;
    for (int n = 0; n < 30; n++) begin
      for (int k = 0; k < 4; k++) rf[k] = rand_vec();
      f = 2'($urandom_range(0, 3));
      sa = 2'($urandom_range(0, 3)); sb = 2'($urandom_range(0, 3));
      dl = 2'($urandom_range(0, 3)); dh = 2'($urandom_range(0, 3));
      r = ref_result(f, rf[sa], rf[sb]);
      exp_q.push_back(r[511:0]);
      if (f == 2'b10) exp_q.push_back(r[1023:512]);
      issue(f, sa, sb, dl, dh);
      lat = 0;
      while (we1 !== 1'b1 && lat < 40) begin
        for (int k = 0; k < 4; k++) rf[k] = rand_vec();
        tick();
        lat++;
      end
      n_cmp++;
      if (lat !== 5) begin
        n_err++;
        $display("FAIL rand_latency[%0d]: got %0d expected 5", n, lat);
        exp_q.delete();
      end else begin
        e = exp_q.pop_front();
        n_cmp++;
        if (out_data1 !== e || out_reg1 !== dl || we2 !== (f == 2'b10)) begin
          n_err++;
          $display("FAIL rand_lo[%0d] op=%0d: got r%0d we2=%b %h expected r%0d %h",
                   n, f, out_reg1, we2, out_data1, dl, e);
        end
        if (f == 2'b10) begin
          e = exp_q.pop_front();
          n_cmp++;
          if (out_data2 !== e || out_reg2 !== dh) begin
            n_err++;
            $display("FAIL rand_hi[%0d]: got r%0d %h expected r%0d %h", n, out_reg2, out_data2, dh, e);
          end
        end
      end
      repeat ($urandom_range(1, 3)) tick();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 4; k++) rf[k] = '0;
    test_reset();
    test_add();
    test_mul();
    test_lanes();
    test_start_held();
    test_reset_mid();
    test_mul_same_dst();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
